cheat_code_detector: RTL

//  Parametrised multi-code key-sequence detector; successor to the single hard-wired god-mode FSM.

---
 rtl/boxhead_keys_pkg.sv | 18 +
 rtl/cheat_code_if.sv | 28 ++
 rtl/cheat_code_tracker.sv | 95 +++++++++
 rtl/cheat_code_detector.sv | 83 ++++++++
 4 files changed

// File: rtl/boxhead_keys_pkg.sv
// Shared keyboard constants and width helpers for the cheat-code detector.
package boxhead_keys_pkg;

  // USB HID keycodes used by the game's cheat sequences
  localparam logic [7:0] KEY_UP    = 8'd82;
  localparam logic [7:0] KEY_DOWN  = 8'd81;
  localparam logic [7:0] KEY_LEFT  = 8'd80;
  localparam logic [7:0] KEY_RIGHT = 8'd79;
  localparam logic [7:0] KEY_Z     = 8'd29;
  localparam logic [7:0] KEY_X     = 8'd27;
  localparam logic [7:0] KEY_SPACE = 8'd44;

  // Width needed to hold a progress/length value in the range 0..max_len
  function automatic int lw_of(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/cheat_code_if.sv
// Bundle between keyboard/game side (master) and the cheat-code detector (slave).
interface cheat_code_if #(
  parameter int NUM_CODES = 2,
  parameter int MAX_LEN   = 12
);
  import boxhead_keys_pkg::*;

  localparam int LW = lw_of(MAX_LEN);

  logic                           frame_tick;
  logic [7:0]                     keycode;
  logic [NUM_CODES*MAX_LEN*8-1:0] code_seq;
  logic [NUM_CODES*LW-1:0]        code_len;
  logic [NUM_CODES-1:0]           match_pulse;
  logic [NUM_CODES-1:0]           active;
  logic [NUM_CODES*LW-1:0]        progress;

  modport master (
    output frame_tick, keycode, code_seq, code_len,
    input  match_pulse, active, progress
  );

  modport slave (
    input  frame_tick, keycode, code_seq, code_len,
    output match_pulse, active, progress
  );

endinterface

// File: rtl/cheat_code_tracker.sv
// One code's progress register, key compare and active flag.
module cheat_code_tracker
  import boxhead_keys_pkg::*;
#(
  parameter int MAX_LEN     = 12,
  parameter int TOGGLE_MODE = 0,
  parameter int LW          = lw_of(MAX_LEN)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_key_event,
  input  logic                 i_abort,
  input  logic                 i_timeout,
  input  logic [7:0]           i_keycode,
  input  logic [MAX_LEN*8-1:0] i_seq,
  input  logic [LW-1:0]        i_len,
  output logic                 o_match_pulse,
  output logic                 o_active,
  output logic [LW-1:0]        o_progress
);

  logic [7:0]    w_step [MAX_LEN];
  logic [LW-1:0] w_len;
  logic [7:0]    w_expect;
  logic [LW-1:0] r_progress, w_progress_next;
  logic          r_match, w_match_next;
  logic          r_active, w_active_next;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_step
      assign w_step[gi] = i_seq[gi*8 +: 8];
    end
  endgenerate

  // Lengths above MAX_LEN are clamped so the compare never runs off the table
  assign w_len = (i_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : i_len;

  // Next progress / match / active; abort has priority over any compare
  always_comb begin
    w_progress_next = r_progress;
    w_match_next    = 1'b0;
    w_active_next   = r_active;
    w_expect        = 8'd0;
    if (r_progress < LW'(MAX_LEN)) begin
      w_expect = w_step[r_progress];
    end
    if (i_key_event) begin
      if (w_len == '0 || i_abort || r_progress >= w_len) begin
        // disabled code, abort, or progress left stale by a shorter new code
        w_progress_next = '0;
      end else if (i_keycode == w_expect) begin
        if (r_progress + LW'(1) == w_len) begin
          w_progress_next = '0;
          w_match_next    = 1'b1;
        end else begin
          w_progress_next = r_progress + LW'(1);
        end
      end else if (i_keycode == w_step[0]) begin
        // wrong key that happens to start the code: restart at step 1
        if (w_len == LW'(1)) begin
          w_progress_next = '0;
          w_match_next    = 1'b1;
        end else begin
          w_progress_next = LW'(1);
        end
      end else begin
        w_progress_next = '0;
      end
    end else if (i_timeout) begin
      w_progress_next = '0;
    end
    if (w_match_next) begin
      w_active_next = (TOGGLE_MODE != 0) ? ~r_active : 1'b1;
    end
  end

  // Tracker state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_progress <= '0;
      r_match    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_progress <= w_progress_next;
      r_match    <= w_match_next;
      r_active   <= w_active_next;
    end
  end

  assign o_match_pulse = r_match;
  assign o_active      = r_active;
  assign o_progress    = r_progress;

endmodule

// File: rtl/cheat_code_detector.sv
// Multi-code key-sequence detector: edge detect, shared frame timeout, abort decode.
module cheat_code_detector
  import boxhead_keys_pkg::*;
#(
  parameter int         NUM_CODES      = 2,
  parameter int         MAX_LEN        = 12,
  parameter int         TIMEOUT_FRAMES = 60,
  parameter logic [7:0] ABORT_KEY      = KEY_SPACE,
  parameter int         TOGGLE_MODE    = 0
) (
  input logic         Clk,
  input logic         Reset,
  cheat_code_if.slave bus
);

  localparam int LW = lw_of(MAX_LEN);
  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);

  logic [7:0]           r_prev_key;
  logic [CW-1:0]        r_frame_cnt, w_frame_cnt_next;
  logic                 w_key_event;
  logic                 w_abort;
  logic                 w_timeout;
  logic [NUM_CODES-1:0] w_match;
  logic [NUM_CODES-1:0] w_active;
  logic [NUM_CODES*LW-1:0] w_progress;

  // A held key produces one event; a direct change to another key is a new event
  assign w_key_event = (bus.keycode != 8'd0) && (bus.keycode != r_prev_key);
  assign w_abort     = (bus.keycode == ABORT_KEY);
  // Fires on the tick that takes the counter to the limit; a same-cycle key wins
  assign w_timeout   = bus.frame_tick && !w_key_event &&
                       (r_frame_cnt == CW'(TIMEOUT_FRAMES - 1));

  // Frame counter: cleared by key events, saturates at the timeout limit
  always_comb begin
    w_frame_cnt_next = r_frame_cnt;
    if (w_key_event) begin
      w_frame_cnt_next = '0;
    end else if (bus.frame_tick && r_frame_cnt != CW'(TIMEOUT_FRAMES)) begin
      w_frame_cnt_next = r_frame_cnt + CW'(1);
    end
  end

  // Previous-key and frame-counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev_key  <= 8'd0;
      r_frame_cnt <= '0;
    end else begin
      r_prev_key  <= bus.keycode;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CODES; gi++) begin : g_code
      cheat_code_tracker #(
        .MAX_LEN     (MAX_LEN),
        .TOGGLE_MODE (TOGGLE_MODE),
        .LW          (LW)
      ) u_tracker (
        .Clk           (Clk),
        .Reset         (Reset),
        .i_key_event   (w_key_event),
        .i_abort       (w_abort),
        .i_timeout     (w_timeout),
        .i_keycode     (bus.keycode),
        .i_seq         (bus.code_seq[gi*MAX_LEN*8 +: MAX_LEN*8]),
        .i_len         (bus.code_len[gi*LW +: LW]),
        .o_match_pulse (w_match[gi]),
        .o_active      (w_active[gi]),
        .o_progress    (w_progress[gi*LW +: LW])
      );
    end
  endgenerate

  assign bus.match_pulse = w_match;
  assign bus.active      = w_active;
  assign bus.progress    = w_progress;

endmodule
